// File: rtl/bsg_activation_feeder_if.sv
// Handshake/bus bundle between the accumulator stream, the activation
// unit and the downstream consumer of bsg_activation_feeder.
interface bsg_activation_feeder_if #(
  parameter int acc_width_p = 32,
  parameter int ang_width_p = 20,
  parameter int ans_width_p = 32
);
  logic                   v_i;
  logic [acc_width_p-1:0] data_i;
  logic                   tanh_i;
  logic                   ready_o;

  logic                   act_v_o;
  logic                   act_ready_i;
  logic [ang_width_p-1:0] act_ang_o;
  logic                   act_tanh_sel_o;
  logic                   act_neg_sel_o;

  logic                   act_v_i;
  logic [ans_width_p-1:0] act_data_i;
  logic                   act_yumi_o;

  logic                   v_o;
  logic [ans_width_p-1:0] data_o;
  logic                   yumi_i;

  modport slave (
    input  v_i, data_i, tanh_i,
    input  act_ready_i, act_v_i, act_data_i,
    input  yumi_i,
    output ready_o,
    output act_v_o, act_ang_o,
    output act_tanh_sel_o, act_neg_sel_o,
    output act_yumi_o,
    output v_o, data_o
  );

  modport master (
    output v_i, data_i, tanh_i,
    output act_ready_i, act_v_i, act_data_i,
    output yumi_i,
    input  ready_o,
    input  act_v_o, act_ang_o,
    input  act_tanh_sel_o, act_neg_sel_o,
    input  act_yumi_o,
    input  v_o, data_o
  );
endinterface

// File: rtl/bsg_activation_feeder.sv
// Queues pre-activation values, issues one saturated-magnitude op at a
// time to the activation unit and returns the sign-corrected result.
module bsg_activation_feeder #(
  parameter int acc_width_p = 32,
  parameter int frac_p      = 16,
  parameter int ang_width_p = 20,
  parameter int ans_width_p = 32,
  parameter int els_p       = 4
) (
  input logic clk_i,
  input logic reset_i,
  bsg_activation_feeder_if.slave io
);

  localparam int lg_els_lp = $clog2(els_p);
  localparam int mag_w_lp  = ang_width_p - 1;

  typedef enum logic {
    e_IDLE,
    e_BUSY
  } state_e;

  typedef struct packed {
    logic [mag_w_lp-1:0] mag;
    logic                neg;
    logic                tanh;
  } entry_s;

  // Angle and result share the binary point, so nothing is rescaled.
  logic [31:0] unused_frac;
  assign unused_frac = 32'(frac_p);

  state_e state_q, state_d;

  entry_s mem_q [els_p];
  entry_s mem_d [els_p];

  logic [lg_els_lp-1:0] rptr_q, rptr_d;
  logic [lg_els_lp-1:0] wptr_q, wptr_d;
  logic [lg_els_lp:0]   cnt_q, cnt_d;

  logic                   v_q, v_d;
  logic [ans_width_p-1:0] data_q, data_d;

  logic                   empty;
  logic                   full;
  logic                   enq;
  logic                   capture;
  logic                   act_v;
  logic                   act_yumi;
  logic                   flip;
  logic                   neg_in;
  logic                   sat_in;
  logic [acc_width_p-1:0] abs_in;
  entry_s                 entry_in;
  entry_s                 head;

  assign neg_in = io.data_i[acc_width_p-1];
  assign abs_in = neg_in
    ? (~io.data_i + acc_width_p'(1))
    : io.data_i;
  // Most-negative input stays negative after negation; MSB catches it.
  assign sat_in = |abs_in[acc_width_p-1:mag_w_lp];

  always_comb begin
    entry_in      = '0;
    entry_in.mag  = sat_in
      ? {mag_w_lp{1'b1}}
      : abs_in[mag_w_lp-1:0];
    entry_in.neg  = neg_in;
    entry_in.tanh = io.tanh_i;
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (lg_els_lp+1)'(els_p));
  assign enq   = io.v_i & ~full;
  assign head  = mem_q[rptr_q];
  assign flip  = head.tanh & head.neg;

  always_comb begin
    mem_d = mem_q;
    if (enq) begin
      mem_d[wptr_q] = entry_in;
    end
  end

  always_comb begin
    wptr_d = wptr_q + lg_els_lp'(enq);
    rptr_d = rptr_q + lg_els_lp'(capture);
    cnt_d  = cnt_q
      + (lg_els_lp+1)'(enq)
      - (lg_els_lp+1)'(capture);
  end

  always_comb begin
    state_d  = state_q;
    act_v    = 1'b0;
    act_yumi = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      e_IDLE: begin
        act_v = ~empty;
        if (act_v & io.act_ready_i) begin
          state_d = e_BUSY;
        end
      end
      e_BUSY: begin
        if (io.act_v_i & (~v_q | io.yumi_i)) begin
          act_yumi = 1'b1;
          capture  = 1'b1;
          state_d  = e_IDLE;
        end
      end
      default: state_d = e_IDLE;
    endcase
  end

  always_comb begin
    v_d    = (v_q & ~io.yumi_i) | capture;
    data_d = data_q;
    unique case (1'b1)
      capture & flip:  data_d = -io.act_data_i;
      capture & ~flip: data_d = io.act_data_i;
      default:         data_d = data_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_IDLE;
      rptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      v_q     <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign io.ready_o        = ~full;
  assign io.act_v_o        = act_v;
  assign io.act_ang_o      = {1'b0, head.mag};
  assign io.act_tanh_sel_o = head.tanh;
  assign io.act_neg_sel_o  = head.neg;
  assign io.act_yumi_o     = act_yumi;
  assign io.v_o            = v_q;
  assign io.data_o         = data_q;

endmodule

// File: tb/tb_bsg_activation_feeder.sv
// Directed bench for bsg_activation_feeder with a fixed-latency
// activation-unit stub.
module tb_bsg_activation_feeder;

  localparam int AW = 32;
  localparam int FW = 16;
  localparam int GW = 20;
  localparam int RW = 32;
  localparam int EL = 4;

  logic clk = 1'b0;
  logic reset_i = 1'b1;

  int checks = 0;
  int failures = 0;

  logic          stub_rdy = 1'b1;
  logic          stub_ang_mode = 1'b0;
  logic [RW-1:0] stub_res = '0;
  int            stub_lat = 2;
  logic          stub_pend = 1'b0;
  int            stub_cnt = 0;

  bsg_activation_feeder_if #(
    .acc_width_p(AW),
    .ang_width_p(GW),
    .ans_width_p(RW)
  ) io ();

  bsg_activation_feeder #(
    .acc_width_p(AW),
    .frac_p(FW),
    .ang_width_p(GW),
    .ans_width_p(RW),
    .els_p(EL)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .io(io.slave)
  );

  always #5 clk = ~clk;

  assign io.act_ready_i = stub_rdy & ~stub_pend & ~io.act_v_i;

  // Activation unit stand-in: accepts, waits stub_lat cycles, holds
  // val_o until the feeder's yumi.
  always @(posedge clk) begin
    logic          iss;
    logic          cap;
    logic          rst;
    logic [GW-1:0] ang;
    rst = reset_i;
    iss = io.act_v_o & io.act_ready_i;
    cap = io.act_v_i & io.act_yumi_o;
    ang = io.act_ang_o;
    #1;
    if (rst) begin
      stub_pend     = 1'b0;
      io.act_v_i    = 1'b0;
      io.act_data_i = '0;
    end else begin
      if (cap) io.act_v_i = 1'b0;
      if (stub_pend) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          stub_pend  = 1'b0;
          io.act_v_i = 1'b1;
        end
      end
      if (iss) begin
        stub_pend     = 1'b1;
        stub_cnt      = stub_lat;
        io.act_data_i = stub_ang_mode ? RW'(ang) : stub_res;
      end
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_act_v(string tag);
    int n = 0;
    while (!io.act_v_i && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_act_v_i"}, 32'(io.act_v_i), 1);
  endtask

  task automatic run_one(
    input logic [31:0] data,
    input logic        tanh,
    input logic [31:0] res,
    input logic [31:0] exp_ang,
    input logic        exp_neg,
    input logic [31:0] exp_out,
    input string       tag
  );
    stub_ang_mode = 1'b0;
    stub_res = res;
    io.v_i = 1'b1;
    io.data_i = data;
    io.tanh_i = tanh;
    #1;
    chk({tag, "_nocomb"}, 32'(io.act_v_o), 0);
    @(negedge clk);
    io.v_i = 1'b0;
    chk({tag, "_act_v_o"}, 32'(io.act_v_o), 1);
    chk({tag, "_ang"}, 32'(io.act_ang_o), exp_ang);
    chk({tag, "_neg"}, 32'(io.act_neg_sel_o), 32'(exp_neg));
    chk({tag, "_tsel"}, 32'(io.act_tanh_sel_o), 32'(tanh));
    wait_act_v(tag);
    chk({tag, "_yumi"}, 32'(io.act_yumi_o), 1);
    chk({tag, "_v_pre"}, 32'(io.v_o), 0);
    @(negedge clk);
    chk({tag, "_v_o"}, 32'(io.v_o), 1);
    chk({tag, "_data"}, io.data_o, exp_out);
    io.yumi_i = 1'b1;
    @(negedge clk);
    io.yumi_i = 1'b0;
    chk({tag, "_v_clr"}, 32'(io.v_o), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int got_n;
    int c0;
    int c1;
    logic [GW-1:0] ang0;

    io.v_i = 1'b0;
    io.data_i = '0;
    io.tanh_i = 1'b0;
    io.yumi_i = 1'b0;
    c0 = 0;
    c1 = 0;

    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(io.ready_o), 1);
    chk("rst_v_o", 32'(io.v_o), 0);
    chk("rst_data", io.data_o, 0);
    chk("rst_act_v", 32'(io.act_v_o), 0);
    chk("rst_act_yumi", 32'(io.act_yumi_o), 0);

    run_one(32'h0001_0000, 1'b1, 32'h0000_C2F7,
            32'h1_0000, 1'b0, 32'h0000_C2F7, "pos_tanh");
    run_one(32'hFFFF_0000, 1'b1, 32'h0000_C2F7,
            32'h1_0000, 1'b1, 32'hFFFF_3D09, "neg_tanh");
    run_one(32'hFFFE_0000, 1'b0, 32'h0000_1E00,
            32'h2_0000, 1'b1, 32'h0000_1E00, "neg_sig");
    run_one(32'h0010_0000, 1'b1, 32'h0000_FFFF,
            32'h7_FFFF, 1'b0, 32'h0000_FFFF, "sat_pos");
    run_one(32'h8000_0000, 1'b1, 32'h0000_FFFF,
            32'h7_FFFF, 1'b1, 32'hFFFF_0001, "sat_min");
    run_one(32'h0007_FFFF, 1'b0, 32'h0000_8000,
            32'h7_FFFF, 1'b0, 32'h0000_8000, "edge_max");
    run_one(32'h0008_0000, 1'b0, 32'h0000_8001,
            32'h7_FFFF, 1'b0, 32'h0000_8001, "edge_sat");
    run_one(32'hFFFF_FFFF, 1'b1, 32'h0000_0010,
            32'h0_0001, 1'b1, 32'hFFFF_FFF0, "neg_one");

    // Fill and backpressure: five values, output not consumed.
    stub_ang_mode = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      io.v_i = 1'b1;
      io.data_i = 32'(k) << 16;
      io.tanh_i = 1'b0;
      n = 0;
      while (!io.ready_o && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      if (k == 4) chk("full_after_4", 32'(io.ready_o), 0);
    end
    io.v_i = 1'b0;
    repeat (2) @(negedge clk);
    ang0 = io.act_ang_o;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (io.act_ang_o !== ang0 || io.act_yumi_o !== 1'b0 ||
          io.act_neg_sel_o !== 1'b0 || io.data_o !== 32'h1_0000)
        bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_head_ang", 32'(io.act_ang_o), 32'h2_0000);
    chk("bp_hold_v", 32'(io.v_o), 1);
    chk("bp_hold_data", io.data_o, 32'h1_0000);
    chk("bp_act_v_i", 32'(io.act_v_i), 1);
    chk("bp_act_yumi", 32'(io.act_yumi_o), 0);

    got_n = 0;
    for (int c = 0; c < 200 && got_n < 5; c++) begin
      io.yumi_i = io.v_o;
      if (io.v_o) begin
        if (got_n == 0) c0 = c;
        if (got_n == 1) c1 = c;
        chk($sformatf("drain%0d", got_n), io.data_o,
            32'(got_n + 1) << 16);
        got_n++;
      end
      @(negedge clk);
    end
    io.yumi_i = 1'b0;
    chk("drain_count", got_n, 5);
    chk("no_bubble", c1 - c0, 1);
    @(negedge clk);

    // Issue stall: activation unit not ready.
    stub_rdy = 1'b0;
    io.v_i = 1'b1;
    io.data_i = 32'h0003_0000;
    io.tanh_i = 1'b1;
    @(negedge clk);
    io.v_i = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!io.act_v_o || io.act_ang_o !== 20'h3_0000 || io.act_v_i)
        bad++;
    end
    chk("stall_hold", bad, 0);
    chk("stall_act_v", 32'(io.act_v_o), 1);
    stub_rdy = 1'b1;
    wait_act_v("stall");
    @(negedge clk);
    chk("stall_v_o", 32'(io.v_o), 1);
    chk("stall_data", io.data_o, 32'h3_0000);
    io.yumi_i = 1'b1;
    @(negedge clk);
    io.yumi_i = 1'b0;

    // Reset while an op is in flight with more queued.
    stub_lat = 20;
    for (int k = 1; k <= 4; k++) begin
      io.v_i = 1'b1;
      io.data_i = 32'(k) << 16;
      io.tanh_i = 1'b0;
      @(negedge clk);
    end
    io.v_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(io.act_v_o), 0);
    chk("pre_rst_full", 32'(io.ready_o), 0);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    chk("mid_rst_v_o", 32'(io.v_o), 0);
    chk("mid_rst_ready", 32'(io.ready_o), 1);
    chk("mid_rst_act_v", 32'(io.act_v_o), 0);
    chk("mid_rst_data", io.data_o, 0);
    stub_lat = 2;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (io.v_o || io.act_v_o || io.act_v_i) bad++;
    end
    chk("post_rst_quiet", bad, 0);

    run_one(32'h0002_8000, 1'b1, 32'h0000_F00D,
            32'h2_8000, 1'b0, 32'h0000_F00D, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
